// File: rtl/load_store_unit.sv
// Data-side load/store unit: one handshaked word access per request. It places store data on the
// correct byte lanes and extracts and extends load data. Misaligned or illegal requests and bus
// timeouts end the access without producing load data.
module load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_store,
    input  logic [2:0]  req_load,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        misalign,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wr_q, wr_d;
    logic [1:0]       store_q, store_d;
    logic [2:0]       load_q, load_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             misalign_q, misalign_d;
    logic             bus_err_q, bus_err_d;

    // A request may reach the bus only if its code is legal and its address is aligned.
    function automatic logic access_ok(input logic wr, input logic [1:0] st,
                                       input logic [2:0] ld, input logic [1:0] off);
        logic ok;
        ok = 1'b0;
        if (wr) begin
            case (st)
                2'b00:   ok = 1'b1;
                2'b01:   ok = ~off[0];
                2'b10:   ok = (off == 2'b00);
                default: ok = 1'b0;
            endcase
        end else begin
            case (ld)
                3'b000, 3'b011: ok = 1'b1;
                3'b001, 3'b100: ok = ~off[0];
                3'b010:         ok = (off == 2'b00);
                default:        ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    function automatic logic [31:0] extract(input logic [2:0] ld, input logic [1:0] off,
                                            input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (ld)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b010:  r = word;
            3'b011:  r = {24'd0, b};
            3'b100:  r = {16'd0, h};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            wr_q       <= 1'b0;
            store_q    <= 2'b00;
            load_q     <= 3'b000;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            rdata_q    <= 32'd0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_q       <= wr_d;
            store_q    <= store_d;
            load_q     <= load_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            misalign_q <= misalign_d;
            bus_err_q  <= bus_err_d;
        end
    end

    // NOTE: every signal gets a hold default first, so no path through the case leaves a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wr_d       = wr_q;
        store_d    = store_q;
        load_d     = load_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        misalign_d = misalign_q;
        bus_err_d  = bus_err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    wr_d    = req_write;
                    store_d = req_store;
                    load_d  = req_load;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = '0;
                    if (access_ok(req_write, req_store, req_load, req_addr[1:0])) begin
                        state_d = S_REQ;
                    end else begin
                        state_d    = S_RESP;
                        rdata_d    = 32'd0;
                        misalign_d = 1'b1;
                        bus_err_d  = 1'b0;
                    end
                end
            end
            S_REQ: begin
                // An ack in the final allowed cycle still completes the access normally.
                if (bus_ack) begin
                    state_d    = S_RESP;
                    cnt_d      = '0;
                    rdata_d    = wr_q ? 32'd0 : extract(load_q, addr_q[1:0], bus_rdata);
                    misalign_d = 1'b0;
                    bus_err_d  = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = S_RESP;
                    cnt_d      = '0;
                    rdata_d    = 32'd0;
                    misalign_d = 1'b0;
                    bus_err_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        stall     = 1'b0;
        done      = 1'b0;
        bus_req   = 1'b0;
        bus_we    = 1'b0;
        bus_addr  = 32'd0;
        bus_be    = 4'b0000;
        bus_wdata = 32'd0;
        case (state_q)
            S_IDLE: stall = req_valid & ~reset;
            S_REQ: begin
                stall    = 1'b1;
                bus_req  = 1'b1;
                bus_we   = wr_q;
                bus_addr = {addr_q[31:2], 2'b00};
                if (!wr_q) begin
                    bus_be = 4'b1111;
                end else begin
                    case (store_q)
                        2'b00: begin
                            bus_be    = 4'b0001 << addr_q[1:0];
                            bus_wdata = {4{wdata_q[7:0]}};
                        end
                        2'b01: begin
                            bus_be    = addr_q[1] ? 4'b1100 : 4'b0011;
                            bus_wdata = {2{wdata_q[15:0]}};
                        end
                        default: begin
                            bus_be    = 4'b1111;
                            bus_wdata = wdata_q;
                        end
                    endcase
                end
            end
            S_RESP:  done = 1'b1;
            default: ;
        endcase
    end

    assign rdata    = rdata_q;
    assign misalign = misalign_q;
    assign bus_err  = bus_err_q;

endmodule
